// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Owns a WIDTH-bit flop bank and gives two requesters shared write access
//   to it. Each command is one of LOAD, PRESET, CLEAR or TOGGLE. A round-robin
//   arbiter accepts one command at a time. The FSM then applies it in one
//   EXEC cycle, pulses done and idles for HOLD_CYCLES before the next grant.
//
//   Ports
//     clk, reset            clock; asynchronous active-low reset
//     reqN_valid/op/data    requester N command (op: 00 LOAD, 01 PRESET,
//                           10 CLEAR, 11 TOGGLE; data = value or toggle mask)
//     reqN_ready            requester N command accepted this cycle
//     q                     flop bank contents
//     busy                  command in EXEC or HOLD
//     done, done_id         one-cycle pulse after EXEC, and the requester it serves
//     q_parity              XOR of q, registered with q (DFF_BANK_PARITY_EN only)
//
//   Optional build macro: DFF_BANK_PARITY_EN adds the q_parity output.
module dff_bank_arbiter #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             done_id
`ifdef DFF_BANK_PARITY_EN
    ,
    output logic             q_parity
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
        logic             id;
    } cmd_t;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             grant;
    logic             accept;
    cmd_t             cmd;
    logic [WIDTH-1:0] q_next;

    // Tie goes to the requester that was not served last; a lone valid wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last;
        else if (req1_valid)          grant = 1'b1;
    end

    // Gating with reset keeps both ready signals low while reset is held.
    assign req0_ready = reset && (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = reset && (state == S_IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state == S_EXEC) || (state == S_HOLD);

    always_comb begin
        q_next = q;
        case (cmd.op)
            OP_LOAD:   q_next = cmd.data;
            OP_PRESET: q_next = '1;
            OP_CLEAR:  q_next = '0;
            OP_TOGGLE: q_next = q ^ cmd.data;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            cmd     <= '0;
            q       <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
`ifdef DFF_BANK_PARITY_EN
            q_parity <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd.op   <= grant ? req1_op   : req0_op;
                        cmd.data <= grant ? req1_data : req0_data;
                        cmd.id   <= grant;
                        last     <= grant;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    q       <= q_next;
`ifdef DFF_BANK_PARITY_EN
                    q_parity <= ^q_next;
`endif
                    done    <= 1'b1;
                    done_id <= cmd.id;
                    if (HOLD_CYCLES > 0) begin
                        cnt   <= CW'(HOLD_CYCLES);
                        state <= S_HOLD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: two instances share the requester inputs, one
// with HOLD_CYCLES=2 (index 0) and one with HOLD_CYCLES=0 (index 1). Directed
// scenario tasks check fixed values. A random phase compares both instances,
// every cycle, against a countdown-style behavioural model.
module tb_dff_bank_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [1:0]   op0 = 2'b00, op1 = 2'b00;
    logic [W-1:0] d0 = '0, d1 = '0;

    logic [1:0]   d_r0, d_r1, d_busy, d_done, d_did, d_par;
    logic [W-1:0] d_q [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [W-1:0] qk;
        assign d_q[k] = qk;
        dff_bank_arbiter #(.WIDTH(W), .HOLD_CYCLES(k == 0 ? 2 : 0)) u_dut (
            .clk(clk), .reset(reset),
            .req0_valid(v0), .req0_op(op0), .req0_data(d0), .req0_ready(d_r0[k]),
            .req1_valid(v1), .req1_op(op1), .req1_data(d1), .req1_ready(d_r1[k]),
            .q(qk), .busy(d_busy[k]), .done(d_done[k]), .done_id(d_did[k])
`ifdef DFF_BANK_PARITY_EN
            , .q_parity(d_par[k])
`endif
        );
`ifndef DFF_BANK_PARITY_EN
        assign d_par[k] = ^qk;
`endif
    end

    // ---------------- behavioural reference model ----------------
    // m_free counts edges until the block may accept again; a command taken
    // at an edge is applied at the following edge.
    int           m_free [2];
    logic         m_last [2];
    logic         m_pend [2];
    logic [1:0]   m_pop  [2];
    logic [W-1:0] m_pdat [2];
    logic         m_pid  [2];
    logic [W-1:0] m_q    [2];
    logic         m_done [2];
    logic         m_did  [2];

    function automatic int hold_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic m_rdy(int k, int n);
        logic g;
        if (!reset || m_free[k] != 0) return 1'b0;
        g = (v0 && v1) ? ~m_last[k] : v1;
        return (n == 0) ? (v0 && !g) : (v1 && g);
    endfunction

    function automatic logic [W-1:0] apply_op(logic [1:0] op, logic [W-1:0] q, logic [W-1:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return {W{1'b1}};
            2'b10:   return '0;
            default: return q ^ d;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_free[k] <= 0;  m_last[k] <= 1'b1; m_pend[k] <= 1'b0;
                m_pop[k]  <= '0; m_pdat[k] <= '0;   m_pid[k]  <= 1'b0;
                m_q[k]    <= '0; m_done[k] <= 1'b0; m_did[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= m_pend[k];
                if (m_pend[k]) begin
                    m_q[k]   <= apply_op(m_pop[k], m_q[k], m_pdat[k]);
                    m_did[k] <= m_pid[k];
                end
                m_pend[k] <= 1'b0;
                if (m_free[k] > 0) begin
                    m_free[k] <= m_free[k] - 1;
                end else if (m_rdy(k, 0) || m_rdy(k, 1)) begin
                    m_pend[k] <= 1'b1;
                    m_pop[k]  <= m_rdy(k, 1) ? op1 : op0;
                    m_pdat[k] <= m_rdy(k, 1) ? d1 : d0;
                    m_pid[k]  <= m_rdy(k, 1);
                    m_last[k] <= m_rdy(k, 1);
                    m_free[k] <= 1 + hold_of(k);
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drop_and_drain(int n);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load0(logic [W-1:0] val);
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 2'b00; d0 = val; v1 = 1'b0;
        drop_and_drain(6);
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset = 1'b0;
        v0 = 1'b1; op0 = 2'b00; d0 = 8'hAA;
        v1 = 1'b1; op1 = 2'b00; d1 = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 5;
            if (d_q[k] !== 8'h00) begin failures++; $display("FAIL reset_q[%0d]: got %h want 00", k, d_q[k]); end
            if (d_r0[k] !== 1'b0) begin failures++; $display("FAIL reset_ready0[%0d]: got %b want 0", k, d_r0[k]); end
            if (d_r1[k] !== 1'b0) begin failures++; $display("FAIL reset_ready1[%0d]: got %b want 0", k, d_r1[k]); end
            if (d_busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", k, d_busy[k]); end
            if (d_done[k] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b want 0", k, d_done[k]); end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (d_r0[k] !== 1'b1) begin failures++; $display("FAIL first_grant_r0[%0d]: got %b want 1", k, d_r0[k]); end
            if (d_r1[k] !== 1'b0) begin failures++; $display("FAIL first_grant_r1[%0d]: got %b want 0", k, d_r1[k]); end
        end
        drop_and_drain(6);
    endtask

    task automatic test_single_load();
        logic [5:0] busy_seen, done_seen;
        logic [W-1:0] q_at2;
        logic         id_at2;
        v0 = 1'b1; op0 = 2'b00; d0 = 8'hA5; v1 = 1'b0;
        @(negedge clk);
        checks++;
        if (d_r0[0] !== 1'b1) begin failures++; $display("FAIL load_ready: got %b want 1", d_r0[0]); end
        @(posedge clk); #1;
        v0 = 1'b0;
        q_at2 = '0; id_at2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            busy_seen[c] = d_busy[0];
            done_seen[c] = d_done[0];
            if (c == 1) begin q_at2 = d_q[0]; id_at2 = d_did[0]; end
        end
        checks += 4;
        if (busy_seen !== 6'b000111) begin failures++; $display("FAIL load_busy: got %b want 000111", busy_seen); end
        if (done_seen !== 6'b000010) begin failures++; $display("FAIL load_done: got %b want 000010", done_seen); end
        if (q_at2 !== 8'hA5) begin failures++; $display("FAIL load_q: got %h want a5", q_at2); end
        if (id_at2 !== 1'b0) begin failures++; $display("FAIL load_done_id: got %b want 0", id_at2); end
    endtask

    task automatic test_ops();
        logic [1:0]   ops  [3] = '{2'b01, 2'b11, 2'b10};
        logic [W-1:0] dat  [3] = '{8'h00, 8'h0F, 8'h00};
        logic [W-1:0] want [3] = '{8'hFF, 8'hF0, 8'h00};
        for (int i = 0; i < 3; i++) begin
            int  ndone;
            logic got, id;
            logic [W-1:0] qd;
            @(posedge clk); #1;
            v1 = 1'b1; op1 = ops[i]; d1 = dat[i];
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = d_r1[0];
            end
            checks++;
            if (!got) begin failures++; $display("FAIL ops_ready_timeout[%0d]: got 0 want 1", i); end
            @(posedge clk); #1;
            v1 = 1'b0;
            ndone = 0; id = 1'b0; qd = 'x;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (d_done[0]) begin ndone++; id = d_did[0]; qd = d_q[0]; end
            end
            checks += 3;
            if (ndone != 1) begin failures++; $display("FAIL ops_done_count[%0d]: got %0d want 1", i, ndone); end
            if (id !== 1'b1) begin failures++; $display("FAIL ops_done_id[%0d]: got %b want 1", i, id); end
            if (qd !== want[i]) begin failures++; $display("FAIL ops_q[%0d]: got %h want %h", i, qd, want[i]); end
        end
    endtask

    task automatic test_contention();
        int gid [$];
        int gcyc [$];
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 2'b00; d0 = 8'h11;
        v1 = 1'b1; op1 = 2'b00; d1 = 8'h22;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_r0[0]) begin gid.push_back(0); gcyc.push_back(c); end
            if (d_r1[0]) begin gid.push_back(1); gcyc.push_back(c); end
            if (d_done[0]) begin
                checks++;
                if (d_q[0] !== (d_did[0] ? 8'h22 : 8'h11)) begin
                    failures++; $display("FAIL cont_q: got %h for id %b", d_q[0], d_did[0]);
                end
            end
        end
        checks++;
        if (gid.size() < 4) begin
            failures++; $display("FAIL cont_grants: got %0d want >=4", gid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gid[i] != i % 2) begin failures++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, gid[i], i % 2); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gcyc[i+1] - gcyc[i] != 4) begin failures++; $display("FAIL cont_spacing[%0d]: got %0d want 4", i, gcyc[i+1] - gcyc[i]); end
            end
        end
        drop_and_drain(6);
    endtask

    task automatic test_hold0();
        int gcyc [$];
        logic [W-1:0] val;
        val = 8'($urandom_range(1, 255));
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 2'b00; d0 = val; v1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (d_r0[1] && d_busy[1]) begin failures++; $display("FAIL hold0_ready_in_exec: got 1 want 0 at cycle %0d", c); end
            if (d_r0[1]) gcyc.push_back(c);
            if (d_done[1]) begin
                checks++;
                if (d_q[1] !== val) begin failures++; $display("FAIL hold0_q: got %h want %h", d_q[1], val); end
            end
        end
        checks++;
        if (gcyc.size() < 5) begin failures++; $display("FAIL hold0_grants: got %0d want >=5", gcyc.size()); end
        for (int i = 0; i + 1 < gcyc.size(); i++) begin
            checks++;
            if (gcyc[i+1] - gcyc[i] != 2) begin failures++; $display("FAIL hold0_spacing[%0d]: got %0d want 2", i, gcyc[i+1] - gcyc[i]); end
        end
        drop_and_drain(6);
    endtask

    task automatic test_mid_reset();
        int ndone;
        @(posedge clk); #1;
        v0 = 1'b1; op0 = 2'b00; d0 = 8'h3C; v1 = 1'b0;
        @(negedge clk);
        checks++;
        if (d_r0[0] !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", d_r0[0]); end
        @(posedge clk); #1;
        v0 = 1'b0;
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (d_q[k] !== 8'h00) begin failures++; $display("FAIL midrst_q[%0d]: got %h want 00", k, d_q[k]); end
            if (d_busy[k] !== 1'b0) begin failures++; $display("FAIL midrst_busy[%0d]: got %b want 0", k, d_busy[k]); end
        end
        ndone = 0;
        v0 = 1'b1; v1 = 1'b1; op1 = 2'b01;
        repeat (2) begin @(negedge clk); ndone += d_done[0] + d_done[1]; end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        ndone += d_done[0] + d_done[1];
        checks += 3;
        if (ndone != 0) begin failures++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
        if (d_r0[0] !== 1'b1) begin failures++; $display("FAIL midrst_regrant_r0: got %b want 1", d_r0[0]); end
        if (d_r1[0] !== 1'b0) begin failures++; $display("FAIL midrst_regrant_r1: got %b want 0", d_r1[0]); end
        drop_and_drain(6);
    endtask

    task automatic test_parity();
        load0(8'h01);
        checks += 2;
        if (d_q[0] !== 8'h01) begin failures++; $display("FAIL par_q01: got %h want 01", d_q[0]); end
        if (d_par[0] !== 1'b1) begin failures++; $display("FAIL par_01: got %b want 1", d_par[0]); end
        load0(8'h03);
        checks += 2;
        if (d_q[0] !== 8'h03) begin failures++; $display("FAIL par_q03: got %h want 03", d_q[0]); end
        if (d_par[0] !== 1'b0) begin failures++; $display("FAIL par_03: got %b want 0", d_par[0]); end
    endtask

    task automatic test_random();
        logic acc0, acc1;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!v0 || acc0) begin
                v0 = ($urandom_range(0, 9) < 7); op0 = 2'($urandom_range(0, 3)); d0 = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) v0 = 1'b0;
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 9) < 7); op1 = 2'($urandom_range(0, 3)); d1 = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) v1 = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks += 7;
                if (d_r0[k] !== m_rdy(k, 0)) begin failures++; $display("FAIL rnd_ready0[%0d] c%0d: got %b want %b", k, c, d_r0[k], m_rdy(k, 0)); end
                if (d_r1[k] !== m_rdy(k, 1)) begin failures++; $display("FAIL rnd_ready1[%0d] c%0d: got %b want %b", k, c, d_r1[k], m_rdy(k, 1)); end
                if (d_q[k] !== m_q[k]) begin failures++; $display("FAIL rnd_q[%0d] c%0d: got %h want %h", k, c, d_q[k], m_q[k]); end
                if (d_busy[k] !== (m_free[k] > 0)) begin failures++; $display("FAIL rnd_busy[%0d] c%0d: got %b want %b", k, c, d_busy[k], m_free[k] > 0); end
                if (d_done[k] !== m_done[k]) begin failures++; $display("FAIL rnd_done[%0d] c%0d: got %b want %b", k, c, d_done[k], m_done[k]); end
                if (d_did[k] !== m_did[k]) begin failures++; $display("FAIL rnd_done_id[%0d] c%0d: got %b want %b", k, c, d_did[k], m_did[k]); end
                if (d_par[k] !== ^m_q[k]) begin failures++; $display("FAIL rnd_parity[%0d] c%0d: got %b want %b", k, c, d_par[k], ^m_q[k]); end
            end
            acc0 = d_r0[0];
            acc1 = d_r1[0];
        end
        drop_and_drain(6);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_ops();
        test_contention();
        test_hold0();
        test_mid_reset();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
